// File: rtl/pu_decode_pipe_if.sv
// Decoded-command type and the beat handshake interface of pu_decode_pipe.
// Build option PU_DECODE_ILLEGAL_EN adds a per-lane illegal flag to dec_type.
package pu_decode_pkg;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  funct5;
      logic        aq;
      logic        rl;
      logic [31:0] imm;
      logic        use_imm;
      logic        op;
      logic        opi;
      logic        load;
      logic        store;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        lui;
      logic        auipc;
      logic        atomic;
      logic        end_program;
      logic        take_branch;
`ifdef PU_DECODE_ILLEGAL_EN
      logic        illegal;
`endif
   } dec_type;

endpackage

interface pu_decode_pipe_if #(
   parameter int IN_WIDTH  = 32,
   parameter int NUM_LANES = 2,
   parameter int PC_WIDTH  = 32
) ();
   import pu_decode_pkg::*;

   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_LANES*IN_WIDTH-1:0] in_inst;
   logic [PC_WIDTH-1:0]           in_pc;
   logic [NUM_LANES-1:0]          in_mask;
   logic                          out_valid;
   logic                          out_ready;
   dec_type [NUM_LANES-1:0]       out_cmd;
   logic [NUM_LANES*PC_WIDTH-1:0] out_pc;
   logic [NUM_LANES-1:0]          out_mask;

   modport master (
      output in_valid, in_inst, in_pc, in_mask, out_ready,
      input  in_ready, out_valid, out_cmd, out_pc, out_mask
   );

   modport slave (
      input  in_valid, in_inst, in_pc, in_mask, out_ready,
      output in_ready, out_valid, out_cmd, out_pc, out_mask
   );

endinterface

// File: rtl/pu_decode_pipe.sv
// Multi-lane RV32I decode stage with a 2-entry skid buffer and RUN/DRAIN/HALT control.
// Build option PU_DECODE_ILLEGAL_EN: flag unknown encodings and stop on them.
module pu_decode_pipe
   import pu_decode_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int NUM_LANES = 2,
   parameter int PC_WIDTH  = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            restart,
   pu_decode_pipe_if.slave bus,
   output logic            halted
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

   typedef struct packed {
      dec_type [NUM_LANES-1:0]       cmd;
      logic [NUM_LANES*PC_WIDTH-1:0] pc;
      logic [NUM_LANES-1:0]          mask;
   } beat_t;

   function automatic dec_type decode(input logic [31:0] x);
      dec_type    d;
      logic [6:0] opc;
      d          = '0;
      opc        = x[6:0];
      d.rs1      = x[19:15];
      d.rs2      = x[24:20];
      d.rd       = x[11:7];
      d.funct3   = x[14:12];
      d.funct7   = x[31:25];
      d.funct5   = x[31:27];
      d.aq       = x[26];
      d.rl       = x[25];
      unique case (1'b1)
         opc == 7'h33: d.op     = 1'b1;
         opc == 7'h13: d.opi    = 1'b1;
         opc == 7'h03: d.load   = 1'b1;
         opc == 7'h23: d.store  = 1'b1;
         opc == 7'h63: d.branch = 1'b1;
         opc == 7'h6f: d.jal    = 1'b1;
         opc == 7'h67: d.jalr   = 1'b1;
         opc == 7'h37: d.lui    = 1'b1;
         opc == 7'h17: d.auipc  = 1'b1;
         (opc == 7'h2f) && (x[14:12] == 3'b010):
            d.atomic = 1'b1;
         opc == 7'h73: d.end_program = 1'b1;
         default: ;
      endcase
      unique case (1'b1)
         d.opi || d.load || d.jalr:
            d.imm = {{21{x[31]}}, x[30:20]};
         d.store:
            d.imm = {{21{x[31]}}, x[30:25], x[11:7]};
         d.branch:
            d.imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
         d.jal:
            d.imm = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
         d.lui || d.auipc:
            d.imm = {x[31:12], 12'b0};
         default:
            d.imm = '0;
      endcase
      d.use_imm = d.opi | d.load | d.store | d.branch
                | d.jal | d.jalr | d.lui | d.auipc;
`ifdef PU_DECODE_ILLEGAL_EN
      d.illegal = ~(d.op | d.use_imm | d.atomic | d.end_program);
`endif
      return d;
   endfunction

   function automatic logic stops(input dec_type d);
`ifdef PU_DECODE_ILLEGAL_EN
      return d.end_program | d.illegal;
`else
      return d.end_program;
`endif
   endfunction

   state_e     st_q, st_d;
   beat_t      e0_q, e0_d, e1_q, e1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       alive_q;
   beat_t      beat_c;
   logic       has_end;
   logic       in_rdy, out_vld, acc, deq;

   // Lanes behind the first present stopping lane are dropped.
   always_comb begin
      beat_c  = '0;
      has_end = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         beat_c.cmd[i] = decode(bus.in_inst[i*IN_WIDTH +: 32]);
         beat_c.pc[i*PC_WIDTH +: PC_WIDTH] =
            bus.in_pc + PC_WIDTH'(4 * i);
         beat_c.mask[i] = bus.in_mask[i] & ~has_end;
         if (beat_c.mask[i] && stops(beat_c.cmd[i]))
            has_end = 1'b1;
      end
   end

   assign in_rdy  = alive_q && (cnt_q < 2'd2) && (st_q == RUN);
   assign out_vld = (cnt_q != 2'd0);
   assign acc     = bus.in_valid & in_rdy & ~flush;
   assign deq     = out_vld & bus.out_ready;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (deq)
            e0_d = e1_q;
         if (acc) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && deq))
               e0_d = beat_c;
            else
               e1_d = beat_c;
         end
         cnt_d = cnt_q + {1'b0, acc} - {1'b0, deq};
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         RUN:
            if (acc && has_end)
               st_d = DRAIN;
         DRAIN:
            if (flush)
               st_d = RUN;
            else if (cnt_q == 2'd0)
               st_d = HALT;
         HALT:
            if (!flush && restart)
               st_d = RUN;
         default:
            st_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st_q    <= RUN;
         e0_q    <= '0;
         e1_q    <= '0;
         cnt_q   <= 2'd0;
         alive_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         cnt_q   <= cnt_d;
         alive_q <= 1'b1;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_cmd   = out_vld ? e0_q.cmd  : '0;
   assign bus.out_pc    = out_vld ? e0_q.pc   : '0;
   assign bus.out_mask  = out_vld ? e0_q.mask : '0;
   assign halted        = (st_q == HALT);

endmodule

// File: tb/tb_pu_decode_pipe.sv
// Bench for pu_decode_pipe: directed scenarios, then random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_pu_decode_pipe;
   import pu_decode_pkg::*;

   localparam int N  = 2;
   localparam int IW = 32;
   localparam int PW = 32;

   typedef struct packed {
      dec_type [N-1:0] cmd;
      logic [N*PW-1:0] pc;
      logic [N-1:0]    mask;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic flush = 1'b0;
   logic restart = 1'b0;
   logic halted;

   pu_decode_pipe_if #(.IN_WIDTH(IW), .NUM_LANES(N), .PC_WIDTH(PW)) bus ();

   pu_decode_pipe #(.IN_WIDTH(IW), .NUM_LANES(N), .PC_WIDTH(PW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (flush),
      .restart (restart),
      .bus     (bus),
      .halted  (halted)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t q[$];
   int   m_st = 0;
   bit   m_alive = 1'b0;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic dec_type ref_decode(input logic [31:0] x);
      dec_type     d;
      logic [31:0] sg, iI, iS, iB, iU, iJ;
      d  = '0;
      sg = {32{x[31]}};
      iI = (sg << 11) | 32'(x[30:20]);
      iS = (sg << 11) | (32'(x[30:25]) << 5) | 32'(x[11:7]);
      iB = (sg << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5)
         | (32'(x[11:8]) << 1);
      iU = x & 32'hFFFF_F000;
      iJ = (sg << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11)
         | (32'(x[30:21]) << 1);
      d.rs1 = x[19:15];  d.rs2 = x[24:20];  d.rd = x[11:7];
      d.funct3 = x[14:12];  d.funct7 = x[31:25];  d.funct5 = x[31:27];
      d.aq = x[26];  d.rl = x[25];
      case (x[6:0])
         7'h33: d.op = 1'b1;
         7'h13: begin d.opi = 1'b1;    d.imm = iI; d.use_imm = 1'b1; end
         7'h03: begin d.load = 1'b1;   d.imm = iI; d.use_imm = 1'b1; end
         7'h23: begin d.store = 1'b1;  d.imm = iS; d.use_imm = 1'b1; end
         7'h63: begin d.branch = 1'b1; d.imm = iB; d.use_imm = 1'b1; end
         7'h6f: begin d.jal = 1'b1;    d.imm = iJ; d.use_imm = 1'b1; end
         7'h67: begin d.jalr = 1'b1;   d.imm = iI; d.use_imm = 1'b1; end
         7'h37: begin d.lui = 1'b1;    d.imm = iU; d.use_imm = 1'b1; end
         7'h17: begin d.auipc = 1'b1;  d.imm = iU; d.use_imm = 1'b1; end
         7'h2f: d.atomic = (x[14:12] == 3'b010);
         7'h73: d.end_program = 1'b1;
         default: ;
      endcase
`ifdef PU_DECODE_ILLEGAL_EN
      d.illegal = !(d.op || d.use_imm || d.atomic || d.end_program);
`endif
      return d;
   endfunction

   function automatic bit ends(input dec_type d);
`ifdef PU_DECODE_ILLEGAL_EN
      return d.end_program || d.illegal;
`else
      return d.end_program;
`endif
   endfunction

   function automatic exp_t ref_beat(input logic [N*IW-1:0] inst,
                                     input logic [PW-1:0] pc,
                                     input logic [N-1:0] m);
      exp_t e;
      bit   stop;
      e    = '0;
      stop = 1'b0;
      for (int i = 0; i < N; i++) begin
         e.cmd[i] = ref_decode(inst[i*IW +: 32]);
         e.pc[i*PW +: PW] = pc + PW'(4 * i);
         e.mask[i] = m[i] && !stop;
         if (e.mask[i] && ends(e.cmd[i]))
            stop = 1'b1;
      end
      return e;
   endfunction

   function automatic bit exp_ready();
      return m_alive && (q.size() < 2) && (m_st == 0);
   endfunction

   function automatic logic [12:0] flags(input dec_type d);
      return {d.use_imm, d.op, d.opi, d.load, d.store, d.branch, d.jal,
              d.jalr, d.lui, d.auipc, d.atomic, d.end_program,
              d.take_branch};
   endfunction

   // Check outputs against the model, clock once, then advance the model.
   task automatic tick();
      bit          inf, outf, r, f, rs, has_end;
      int          pre;
      exp_t        e;
      chk("in_ready", bus.in_ready, exp_ready());
      chk("halted", halted, m_st == 2);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_cmd", bus.out_cmd, q[0].cmd);
         chk("out_pc", bus.out_pc, q[0].pc);
         chk("out_mask", bus.out_mask, q[0].mask);
      end else begin
         chk("idle_out", {bus.out_cmd, bus.out_pc, bus.out_mask}, '0);
      end
      r    = rstn;
      f    = flush;
      rs   = restart;
      inf  = r && !f && bus.in_valid && exp_ready();
      outf = (q.size() != 0) && bus.out_ready;
      e    = ref_beat(bus.in_inst, bus.in_pc, bus.in_mask);
      has_end = 1'b0;
      for (int i = 0; i < N; i++)
         if (e.mask[i] && ends(e.cmd[i])) has_end = 1'b1;
      @(posedge clk);
      if (!r) begin
         q.delete();
         m_st    = 0;
         m_alive = 1'b0;
      end else begin
         m_alive = 1'b1;
         pre     = q.size();
         if (f) begin
            q.delete();
            if (m_st == 1) m_st = 0;
         end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(e);
            case (m_st)
               0: if (inf && has_end) m_st = 1;
               1: if (pre == 0) m_st = 2;
               2: if (rs) m_st = 0;
               default: ;
            endcase
         end
      end
      #1;
   endtask

   task automatic offer(input logic [N*IW-1:0] inst, input logic [PW-1:0] pc,
                        input logic [N-1:0] m);
      bit got;
      got = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.in_mask  = m;
      for (int k = 0; k < 20 && !got; k++) begin
         got = exp_ready();
         tick();
      end
      chk("accept_timeout", got, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [12];
      logic [31:0] x;
      int          k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f,
              7'h67, 7'h37, 7'h17, 7'h2f, 7'h73, 7'h7f};
      x = $urandom;
      k = $urandom_range(0, 199);
      if (k < 4)       x[6:0] = 7'h73;
      else if (k < 8)  x[6:0] = 7'h7f;
      else             x[6:0] = ops[k % 10];
      if (x[6:0] == 7'h2f && x[31]) x[14:12] = 3'b010;
      return x;
   endfunction

   localparam logic [31:0] ADDI = 32'h0050_0093;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_pc     = '0;
      bus.in_mask   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tick();
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_outs", {bus.out_valid, halted, bus.out_mask}, '0);
      rstn = 1'b1;
      tick();
      chk("first_ready", bus.in_ready, 1'b1);

      // single beat: addi x1,x0,5 / add x2,x1,x2
      bus.out_ready = 1'b1;
      offer({32'h0020_8133, ADDI}, 32'h100, 2'b11);
      chk("sb_valid", bus.out_valid, 1'b1);
      chk("sb_l0_opi", bus.out_cmd[0].opi, 1'b1);
      chk("sb_l0_rd", bus.out_cmd[0].rd, 5'd1);
      chk("sb_l0_imm", bus.out_cmd[0].imm, 32'd5);
      chk("sb_l1_op", bus.out_cmd[1].op, 1'b1);
      chk("sb_l1_regs", {bus.out_cmd[1].rd, bus.out_cmd[1].rs1,
                         bus.out_cmd[1].rs2}, {5'd2, 5'd1, 5'd2});
      chk("sb_l1_pc", bus.out_pc[PW +: PW], 32'h104);
      tick();

      // beq x0,x0,-4
      offer({ADDI, 32'hFE00_0EE3}, 32'h200, 2'b01);
      chk("br_flag", bus.out_cmd[0].branch, 1'b1);
      chk("br_f3", bus.out_cmd[0].funct3, 3'b000);
      chk("br_imm", bus.out_cmd[0].imm, 32'hFFFF_FFFC);
      chk("br_take", bus.out_cmd[0].take_branch, 1'b0);
      tick();

      // backpressure: three beats against a stalled output
      bus.out_ready = 1'b0;
      offer({rand_inst() & 32'hFFFF_FF83 | 32'h33, ADDI}, 32'h300, 2'b11);
      offer({ADDI, 32'h0000_0033}, 32'h308, 2'b11);
      chk("bp_full", bus.in_ready, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_inst  = {32'h0000_0037, 32'h0000_0017};
      bus.in_pc    = 32'h310;
      bus.in_mask  = 2'b10;
      repeat (3) tick();
      bus.out_ready = 1'b1;
      offer({32'h0000_0037, 32'h0000_0017}, 32'h310, 2'b10);
      for (int k = 0; k < 10 && q.size() != 0; k++) tick();
      chk("bp_drained", bus.out_valid, 1'b0);

      // restart is ignored outside HALT
      restart = 1'b1;
      tick();
      restart = 1'b0;

      // ecall in lane 0 truncates lane 1 and halts
      offer({ADDI, 32'h0000_0073}, 32'h400, 2'b11);
      chk("halt_mask", bus.out_mask, 2'b01);
      chk("drain_rdy", bus.in_ready, 1'b0);
      for (int k = 0; k < 10 && !halted; k++) tick();
      chk("halt_reached", halted, 1'b1);
      chk("halt_rdy", bus.in_ready, 1'b0);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("restart_run", {halted, bus.in_ready}, 2'b01);

      // flush with two buffered beats blocks the same-cycle accept
      bus.out_ready = 1'b0;
      offer({ADDI, ADDI}, 32'h500, 2'b11);
      offer({ADDI, ADDI}, 32'h508, 2'b11);
      bus.in_valid = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_valid", bus.out_valid, 1'b0);
      tick();

      // flush while draining returns to RUN
      offer({ADDI, 32'h0000_0073}, 32'h600, 2'b01);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_drain", {halted, bus.in_ready}, 2'b01);

      // reset while draining
      offer({ADDI, 32'h0000_0073}, 32'h700, 2'b11);
      rstn = 1'b0;
      tick();
      chk("rst_drain", {bus.out_valid, bus.in_ready, halted,
                        bus.out_mask, bus.out_cmd, bus.out_pc}, '0);
      rstn = 1'b1;
      tick();
      chk("rst_ready", bus.in_ready, 1'b1);

      // unknown opcode
      bus.out_ready = 1'b1;
      offer({ADDI, 32'h0000_007F}, 32'h800, 2'b11);
`ifdef PU_DECODE_ILLEGAL_EN
      chk("ill_flag", bus.out_cmd[0].illegal, 1'b1);
      chk("ill_mask", bus.out_mask, 2'b01);
      for (int k = 0; k < 10 && !halted; k++) tick();
      chk("ill_halt", halted, 1'b1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
`else
      chk("nop_flags", flags(bus.out_cmd[0]), '0);
      chk("nop_mask", bus.out_mask, 2'b11);
      repeat (4) tick();
      chk("nop_run", {halted, bus.in_ready}, 2'b01);
`endif

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_inst   = {rand_inst(), rand_inst()};
         bus.in_pc     = $urandom & 32'hFFFF_FFFC;
         bus.in_mask   = N'($urandom);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         flush         = ($urandom_range(0, 59) == 0);
         restart       = ($urandom_range(0, 3) == 0);
         tick();
      end
      bus.in_valid  = 1'b0;
      flush         = 1'b0;
      restart       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
